pc_fetch: RTL and testbench

- Instruction-fetch front end of the single-cycle MIPS core.
- Owns the PC register and drives the word-aligned address into the instruction ROM.
- Returns the fetched instruction to decode, or a NOP when the instruction is squashed.
- Computes next-PC, vectors reset, interrupt and exception entry, and enforces the kernel bit PC[31].

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/pc_next_calc.sv | 33 +++
 rtl/pc_fetch.sv | 84 ++++++++
 tb/tb_pc_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS fetch front end: vectors, next-PC select
// encodings, opcode values and the supported-opcode lookup.
package cpu_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_J   = 2'd2,
        PCSRC_JR  = 2'd3
    } pc_src_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    function automatic logic op_supported(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: hit = 1'b1;
            default:                      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC for the normal (non-stall, non-trap) flow: PC+4,
// branch target, jump target and register jump with the kernel-bit rule.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] seq_next
);

    logic [30:0] br_sum;
    logic [31:0] target;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        // 31-bit sum so branch arithmetic can never carry into the kernel bit
        br_sum   = pc_plus4[30:0] + {{13{imm16[15]}}, imm16, 2'b00};
        target   = pc_plus4;
        case (pc_src_e'(pc_src))
            PCSRC_BR: if (br_taken) target = {pc[31], br_sum};
            PCSRC_J:  target = {pc_plus4[31:28], jtarget, 2'b00};
            PCSRC_JR: target = {pc[31] & jr_addr[31], jr_addr[30:0]};
            default:  target = pc_plus4;
        endcase
        seq_next = target & 32'hFFFF_FFFC;
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, interrupt sampling and squash.
// Define PCF_ILLOP_EN to add illegal-opcode trapping and the exc_take port.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = cpu_pkg::DEF_RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = cpu_pkg::DEF_IRQ_VEC
`ifdef PCF_ILLOP_EN
   ,parameter logic [31:0] EXC_VEC   = cpu_pkg::DEF_EXC_VEC
`endif
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_addr,
    input  logic        irq,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        irq_take,
`ifdef PCF_ILLOP_EN
    output logic        exc_take,
`endif
    output logic [31:0] xp
);

    logic [31:0] pc_q, pc_d;
    logic        irq_q, irq_d;
    logic [31:0] seq_next;
    logic        exc_hit;

    pc_next_calc u_next (
        .pc       (pc_q),
        .pc_src   (pc_src),
        .br_taken (br_taken),
        .imm16    (imm16),
        .jtarget  (jtarget),
        .jr_addr  (jr_addr),
        .pc_plus4 (pc_plus4),
        .seq_next (seq_next)
    );

    always_comb begin
        irq_take = irq_q & ~pc_q[31] & ~stall;
`ifdef PCF_ILLOP_EN
        exc_hit  = ~op_supported(rom_data[31:26]) & ~pc_q[31] & ~stall & ~irq_take;
`else
        exc_hit  = 1'b0;
`endif
        irq_d = irq;
        if (stall)         pc_d = pc_q;
        else if (irq_take) pc_d = {IRQ_VEC[31:2], 2'b00};
`ifdef PCF_ILLOP_EN
        else if (exc_hit)  pc_d = {EXC_VEC[31:2], 2'b00};
`endif
        else               pc_d = seq_next;
        instr = (irq_take | exc_hit) ? NOP_INSTR : rom_data;
        // interrupts resume at the squashed instruction, traps skip the faulting one
        xp    = exc_hit ? pc_plus4 : pc_q;
    end

`ifdef PCF_ILLOP_EN
    assign exc_take = exc_hit;
`endif
    assign pc       = pc_q;
    assign rom_addr = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            irq_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            irq_q <= irq_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized
// stimulus against a behavioural next-PC model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, irq;
    logic [1:0]  pc_src;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] jr_addr, rom_data;
    logic [31:0] rom_addr, instr, pc, pc_plus4, xp;
    logic        irq_take;
`ifdef PCF_ILLOP_EN
    logic        exc_take;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    logic        m_irq_q;
    logic [5:0]  legal_ops [17] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                    6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .pc_src   (pc_src),
        .br_taken (br_taken),
        .imm16    (imm16),
        .jtarget  (jtarget),
        .jr_addr  (jr_addr),
        .irq      (irq),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .instr    (instr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .irq_take (irq_take),
`ifdef PCF_ILLOP_EN
        .exc_take (exc_take),
`endif
        .xp       (xp)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    function automatic logic m_irq_take();
        return m_irq_q && !m_pc[31] && !stall;
    endfunction

    function automatic logic m_exc_take();
`ifdef PCF_ILLOP_EN
        logic legal;
        legal = 1'b0;
        foreach (legal_ops[k]) if (legal_ops[k] == rom_data[31:26]) legal = 1'b1;
        return !legal && !m_pc[31] && !stall && !m_irq_take();
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_next();
        logic [31:0] p4, t;
        int off;
        p4 = m_pc + 32'd4;
        if (stall)        return m_pc;
        if (m_irq_take()) return 32'h8000_0004;
        if (m_exc_take()) return 32'h8000_0008;
        case (pc_src)
            2'd1: begin
                if (br_taken) begin
                    off = $signed(imm16);
                    off = off * 4;
                    t = p4 + off;
                    t[31] = m_pc[31];
                end else t = p4;
            end
            2'd2: t = (p4 & 32'hF000_0000) | ({6'd0, jtarget} * 32'd4);
            2'd3: begin
                t = jr_addr;
                if (!m_pc[31]) t[31] = 1'b0;
            end
            default: t = p4;
        endcase
        return t & ~32'd3;
    endfunction

    task automatic tick();
        logic [31:0] nx;
        logic iq;
        nx = m_next();
        iq = irq;
        @(posedge clk);
        #1;
        if (!reset) begin m_pc = 32'h8000_0000; m_irq_q = 1'b0; end
        else begin m_pc = nx; m_irq_q = iq; end
    endtask

    function automatic logic [31:0] legal_word();
        logic [31:0] r;
        r = $urandom;
        return {6'h09, r[25:0]};
    endfunction

    task automatic set_idle();
        stall = 0; pc_src = 2'd0; br_taken = 0; irq = 0;
        imm16 = '0; jtarget = '0; jr_addr = '0; rom_data = legal_word();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        reset = 0; irq = 1;
        repeat (2) tick();
        n_cmp++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h8000_0000); end
        n_cmp++; if (rom_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_rom_addr: got %h exp %h", rom_addr, 32'h8000_0000); end
        n_cmp++; if (pc_plus4 !== 32'h8000_0004) begin n_fail++; $display("FAIL reset_pc_plus4: got %h exp %h", pc_plus4, 32'h8000_0004); end
        n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL reset_irq_take: got %b exp 0", irq_take); end
        reset = 1; irq = 0;
        #1;
        n_cmp++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_release_pc: got %h exp %h", pc, 32'h8000_0000); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (pc !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL reset_seq_%0d: got %h exp %h", i, pc, 32'h8000_0000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_kernel_exit();
        set_idle();
        pc_src = 2'd2; jtarget = 26'h2E;
        tick();
        n_cmp++; if (pc !== 32'h8000_00B8) begin n_fail++; $display("FAIL kjump_pc: got %h exp %h", pc, 32'h8000_00B8); end
        pc_src = 2'd3; jr_addr = 32'h0000_00A8;
        tick();
        n_cmp++; if (pc !== 32'h0000_00A8) begin n_fail++; $display("FAIL kexit_pc: got %h exp %h", pc, 32'h0000_00A8); end
        jr_addr = 32'h8000_0010;
        tick();
        n_cmp++; if (pc !== 32'h0000_0010) begin n_fail++; $display("FAIL user_jr_kbit: got %h exp %h", pc, 32'h0000_0010); end
    endtask

    task automatic test_branch();
        set_idle();
        pc_src = 2'd2; jtarget = 26'h58;
        tick();
        n_cmp++; if (pc !== 32'h0000_0160) begin n_fail++; $display("FAIL br_setup_pc: got %h exp %h", pc, 32'h0000_0160); end
        pc_src = 2'd1; br_taken = 1; imm16 = 16'hFFF8; rom_data = legal_word();
        #1;
        n_cmp++; if (instr !== rom_data) begin n_fail++; $display("FAIL br_instr: got %h exp %h", instr, rom_data); end
        tick();
        n_cmp++; if (pc !== 32'h0000_0144) begin n_fail++; $display("FAIL br_taken_pc: got %h exp %h", pc, 32'h0000_0144); end
        pc_src = 2'd2; br_taken = 0;
        tick();
        pc_src = 2'd1;
        tick();
        n_cmp++; if (pc !== 32'h0000_0164) begin n_fail++; $display("FAIL br_not_taken_pc: got %h exp %h", pc, 32'h0000_0164); end
    endtask

    task automatic test_interrupt();
        set_idle();
        pc_src = 2'd2; jtarget = 26'h54;
        tick();
        pc_src = 2'd0; irq = 1;
        #1;
        n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b exp 0", irq_take); end
        tick();
        // branch in the same cycle as the interrupt must be discarded
        pc_src = 2'd1; br_taken = 1; imm16 = 16'h0010; rom_data = legal_word();
        #1;
        n_cmp++; if (irq_take !== 1'b1) begin n_fail++; $display("FAIL irq_take: got %b exp 1", irq_take); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL irq_squash: got %h exp 0", instr); end
        n_cmp++; if (xp !== 32'h0000_0154) begin n_fail++; $display("FAIL irq_xp: got %h exp %h", xp, 32'h0000_0154); end
        tick();
        n_cmp++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL irq_vec: got %h exp %h", pc, 32'h8000_0004); end
        pc_src = 2'd0; br_taken = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL irq_kernel_mask_%0d: got %b exp 0", i, irq_take); end
            tick();
        end
        irq = 0;
        tick();
    endtask

    task automatic test_stall_irq();
        set_idle();
        pc_src = 2'd3; jr_addr = 32'h0000_0300;
        tick();
        pc_src = 2'd0; stall = 1; irq = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (pc !== 32'h0000_0300) begin n_fail++; $display("FAIL stall_pc_%0d: got %h exp %h", i, pc, 32'h0000_0300); end
            n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL stall_irq_%0d: got %b exp 0", i, irq_take); end
            n_cmp++; if (instr !== rom_data) begin n_fail++; $display("FAIL stall_instr_%0d: got %h exp %h", i, instr, rom_data); end
            tick();
        end
        stall = 0;
        #1;
        n_cmp++; if (irq_take !== 1'b1) begin n_fail++; $display("FAIL unstall_irq_take: got %b exp 1", irq_take); end
        n_cmp++; if (xp !== 32'h0000_0300) begin n_fail++; $display("FAIL unstall_xp: got %h exp %h", xp, 32'h0000_0300); end
        tick();
        n_cmp++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL unstall_vec: got %h exp %h", pc, 32'h8000_0004); end
        irq = 0;
        tick();
    endtask

    task automatic test_irq_drop();
        set_idle();
        pc_src = 2'd3; jr_addr = 32'h0000_0400;
        tick();
        pc_src = 2'd0; irq = 1;
        tick();
        irq = 0; stall = 1;
        #1;
        n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL drop_stalled: got %b exp 0", irq_take); end
        tick();
        stall = 0;
        #1;
        n_cmp++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL drop_after: got %b exp 0", irq_take); end
        tick();
        n_cmp++; if (pc !== 32'h0000_0408) begin n_fail++; $display("FAIL drop_pc: got %h exp %h", pc, 32'h0000_0408); end
    endtask

`ifdef PCF_ILLOP_EN
    task automatic test_illop();
        set_idle();
        pc_src = 2'd2; jtarget = 26'h80;
        tick();
        pc_src = 2'd0; rom_data = 32'hFC00_0000;
        #1;
        n_cmp++; if (exc_take !== 1'b1) begin n_fail++; $display("FAIL exc_take: got %b exp 1", exc_take); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL exc_squash: got %h exp 0", instr); end
        n_cmp++; if (xp !== 32'h0000_0204) begin n_fail++; $display("FAIL exc_xp: got %h exp %h", xp, 32'h0000_0204); end
        tick();
        n_cmp++; if (pc !== 32'h8000_0008) begin n_fail++; $display("FAIL exc_vec: got %h exp %h", pc, 32'h8000_0008); end
        n_cmp++; if (exc_take !== 1'b0) begin n_fail++; $display("FAIL exc_kernel: got %b exp 0", exc_take); end
        n_cmp++; if (instr !== 32'hFC00_0000) begin n_fail++; $display("FAIL exc_kernel_instr: got %h exp %h", instr, 32'hFC00_0000); end
        pc_src = 2'd3; jr_addr = 32'h0000_0200; irq = 1;
        tick();
        pc_src = 2'd0;
        #1;
        n_cmp++; if (irq_take !== 1'b1) begin n_fail++; $display("FAIL exc_irq_prio_take: got %b exp 1", irq_take); end
        n_cmp++; if (exc_take !== 1'b0) begin n_fail++; $display("FAIL exc_irq_prio_exc: got %b exp 0", exc_take); end
        n_cmp++; if (xp !== 32'h0000_0200) begin n_fail++; $display("FAIL exc_irq_prio_xp: got %h exp %h", xp, 32'h0000_0200); end
        tick();
        n_cmp++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL exc_irq_prio_vec: got %h exp %h", pc, 32'h8000_0004); end
        irq = 0; rom_data = legal_word();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] r, e_instr, e_xp;
        logic [5:0]  op;
        logic        e_take, e_exc;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 16)];
            rom_data = {op, r[25:0]};
            stall    = ($urandom_range(0, 3) == 0);
            irq      = ($urandom_range(0, 2) == 0);
            pc_src   = 2'($urandom);
            br_taken = 1'($urandom);
            imm16    = 16'($urandom);
            jtarget  = 26'($urandom);
            jr_addr  = $urandom;
            #1;
            e_take  = m_irq_take();
            e_exc   = m_exc_take();
            e_instr = (e_take || e_exc) ? 32'h0 : rom_data;
            e_xp    = e_exc ? m_pc + 32'd4 : m_pc;
            n_cmp++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h exp %h", i, pc, m_pc); end
            n_cmp++; if (rom_addr !== m_pc) begin n_fail++; $display("FAIL rnd_rom_addr[%0d]: got %h exp %h", i, rom_addr, m_pc); end
            n_cmp++; if (pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc_plus4[%0d]: got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
            n_cmp++; if (irq_take !== e_take) begin n_fail++; $display("FAIL rnd_irq_take[%0d]: got %b exp %b", i, irq_take, e_take); end
            n_cmp++; if (instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h exp %h", i, instr, e_instr); end
            n_cmp++; if (xp !== e_xp) begin n_fail++; $display("FAIL rnd_xp[%0d]: got %h exp %h", i, xp, e_xp); end
`ifdef PCF_ILLOP_EN
            n_cmp++; if (exc_take !== e_exc) begin n_fail++; $display("FAIL rnd_exc_take[%0d]: got %b exp %b", i, exc_take, e_exc); end
`endif
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_idle();
        tick();
        pc_src = 2'd3; jr_addr = 32'h0000_0500;
        tick();
        n_cmp++; if (pc !== 32'h0000_0500) begin n_fail++; $display("FAIL areset_setup: got %h exp %h", pc, 32'h0000_0500); end
        #2 reset = 0;
        #1;
        n_cmp++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL areset_pc: got %h exp %h", pc, 32'h8000_0000); end
        n_cmp++; if (rom_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL areset_rom_addr: got %h exp %h", rom_addr, 32'h8000_0000); end
        tick();
        reset = 1; pc_src = 2'd0;
        tick();
        n_cmp++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL areset_resume: got %h exp %h", pc, 32'h8000_0004); end
    endtask

    initial begin
        reset = 0;
        set_idle();
        m_pc = 32'h8000_0000;
        m_irq_q = 1'b0;
        test_reset();
        test_kernel_exit();
        test_branch();
        test_interrupt();
        test_stall_irq();
        test_irq_drop();
`ifdef PCF_ILLOP_EN
        test_illop();
`endif
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
